// File: rtl/pipe_stage_skid.sv
// Reusable pipeline stage register with valid/ready handshake, flush-to-bubble
// and an optional skid entry that keeps in_ready registered.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 9,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic              vld_p0;
  logic              rdy_q;
  logic [CTRL_W-1:0] main_ctrl_p0;
  logic [DATA_W-1:0] main_data_p0;
  logic [CTRL_W-1:0] skid_ctrl_p0;
  logic [DATA_W-1:0] skid_data_p0;

  logic acc;
  logic pop;
  logic load_in;
  logic load_from_skid;
  logic load_skid;
  logic clr_ctrl;

  // Without a skid entry, a held instruction may be replaced in the same
  // cycle it leaves, so in_ready must look at out_ready combinationally.
  assign in_ready  = (SKID != 0) ? rdy_q : (!vld_p0 || out_ready);
  assign acc       = in_valid && in_ready;
  assign pop       = vld_p0 && out_ready;

  assign out_valid = vld_p0;
  assign out_ctrl  = main_ctrl_p0;
  assign out_data  = main_data_p0;
  assign occupancy = state_q;

  always_comb begin
    state_nxt      = state_q;
    load_in        = 1'b0;
    load_from_skid = 1'b0;
    load_skid      = 1'b0;
    clr_ctrl       = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
      clr_ctrl  = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_nxt = ST_ONE;
            load_in   = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            load_in = 1'b1;
          end else if (acc) begin
            if (SKID != 0) begin
              state_nxt = ST_FULL;
              load_skid = 1'b1;
            end
          end else if (pop) begin
            state_nxt = ST_EMPTY;
            clr_ctrl  = 1'b1;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_nxt      = ST_ONE;
            load_from_skid = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
          clr_ctrl  = 1'b1;
        end
      endcase
    end
  end

  // Stage p0: main (output) entry plus skid entry behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      vld_p0       <= 1'b0;
      rdy_q        <= 1'b1;
      main_ctrl_p0 <= '0;
      main_data_p0 <= '0;
      skid_ctrl_p0 <= '0;
      skid_data_p0 <= '0;
    end else begin
      state_q <= state_nxt;
      vld_p0  <= (state_nxt != ST_EMPTY);
      rdy_q   <= (state_nxt != ST_FULL);
      // ctrl is zeroed on every transition to EMPTY so a bubble never carries write enables
      if (clr_ctrl) begin
        main_ctrl_p0 <= '0;
      end else if (load_in) begin
        main_ctrl_p0 <= in_ctrl;
      end else if (load_from_skid) begin
        main_ctrl_p0 <= skid_ctrl_p0;
      end
      if (load_in) begin
        main_data_p0 <= in_data;
      end else if (load_from_skid) begin
        main_data_p0 <= skid_data_p0;
      end
      if (load_skid) begin
        skid_ctrl_p0 <= in_ctrl;
        skid_data_p0 <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and scoreboard-checked bench for pipe_stage_skid, covering both
// the SKID=1 (two-entry) and SKID=0 (single-entry) builds on shared inputs.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 9;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_ready;

  logic              in_ready;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  logic              z_in_ready;
  logic              z_out_valid;
  logic [CTRL_W-1:0] z_out_ctrl;
  logic [DATA_W-1:0] z_out_data;
  logic [1:0]        z_occupancy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [CTRL_W+DATA_W-1:0] q1[$];
  logic [CTRL_W+DATA_W-1:0] q0[$];

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .occupancy(occupancy)
  );

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_ctrl(z_out_ctrl),
    .out_data(z_out_data), .occupancy(z_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0);
    flush = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 9'h1FF, 32'hDEAD_BEEF);

    // 1: reset with garbage on the inputs
    cyc();
    cyc();
    rst = 1'b0;
    drive(1'b0, '0, '0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_data", out_data, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_z_ready", z_in_ready, 1);

    // 2: streaming, one transfer per cycle
    out_ready = 1'b1;
    drive(1'b1, 9'h011, 32'h100);
    cyc();
    chk("str0_valid", out_valid, 1);
    chk("str0_data", out_data, 32'h100);
    chk("str0_ctrl", out_ctrl, 9'h011);
    chk("str0_occ", occupancy, 1);
    drive(1'b1, 9'h012, 32'h104);
    cyc();
    chk("str1_data", out_data, 32'h104);
    chk("str1_occ", occupancy, 1);
    chk("str1_ready", in_ready, 1);
    drive(1'b1, 9'h013, 32'h108);
    cyc();
    chk("str2_data", out_data, 32'h108);
    chk("str2_ctrl", out_ctrl, 9'h013);
    chk("str2_occ", occupancy, 1);
    drive(1'b0, '0, '0);
    cyc();
    chk("str_end_valid", out_valid, 0);
    chk("str_end_ctrl", out_ctrl, 0);
    chk("str_end_data_held", out_data, 32'h108);
    chk("str_end_occ", occupancy, 0);

    // 3: stall fills the skid entry, then drains in order
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 9'h0A1, 32'hA);
    cyc();
    chk("stall1_occ", occupancy, 1);
    chk("stall1_ready", in_ready, 1);
    drive(1'b1, 9'h0B1, 32'hB);
    cyc();
    chk("stall2_occ", occupancy, 2);
    chk("stall2_ready", in_ready, 0);
    chk("stall2_data", out_data, 32'hA);
    chk("stall2_ctrl", out_ctrl, 9'h0A1);
    drive(1'b0, '0, '0);
    cyc();
    chk("stall_hold_occ", occupancy, 2);
    chk("stall_hold_data", out_data, 32'hA);
    out_ready = 1'b1;
    cyc();
    chk("drain1_data", out_data, 32'hB);
    chk("drain1_ctrl", out_ctrl, 9'h0B1);
    chk("drain1_occ", occupancy, 1);
    chk("drain1_ready", in_ready, 1);
    cyc();
    chk("drain2_valid", out_valid, 0);
    chk("drain2_ctrl", out_ctrl, 0);

    // 4: flush while FULL with a pending input
    out_ready = 1'b0;
    drive(1'b1, 9'h021, 32'h1);
    cyc();
    drive(1'b1, 9'h022, 32'h2);
    cyc();
    chk("pre_flush_occ", occupancy, 2);
    drive(1'b1, 9'h0CC, 32'hC);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_valid", out_valid, 0);
    chk("flush_ctrl", out_ctrl, 0);
    chk("flush_occ", occupancy, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_data_kept", out_data, 32'h1);
    out_ready = 1'b1;
    cyc();
    chk("flush_no_c_valid", out_valid, 0);
    chk("flush_no_c_data", out_data, 32'h1);
    // flush in ONE drops an accept of the same cycle
    drive(1'b1, 9'h0D1, 32'hD);
    cyc();
    drive(1'b1, 9'h0E1, 32'hE);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush1_valid", out_valid, 0);
    chk("flush1_data", out_data, 32'hD);
    chk("flush1_occ", occupancy, 0);

    // 5: single-entry build
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 9'h055, 32'h50);
    #1;
    chk("z_empty_ready", z_in_ready, 1);
    cyc();
    chk("z_held_valid", z_out_valid, 1);
    chk("z_held_data", z_out_data, 32'h50);
    chk("z_held_occ", z_occupancy, 1);
    chk("z_stall_ready", z_in_ready, 0);
    out_ready = 1'b1;
    drive(1'b1, 9'h056, 32'h54);
    #1;
    chk("z_pass_ready", z_in_ready, 1);
    cyc();
    chk("z_repl_valid", z_out_valid, 1);
    chk("z_repl_data", z_out_data, 32'h54);
    chk("z_repl_ctrl", z_out_ctrl, 9'h056);
    chk("z_repl_occ", z_occupancy, 1);
    drive(1'b0, '0, '0);
    cyc();
    chk("z_empty_valid", z_out_valid, 0);
    chk("z_empty_ctrl", z_out_ctrl, 0);

    // 6: random valid/ready/flush against a FIFO scoreboard for both builds
    do_reset();
    q1.delete();
    q0.delete();
    for (int i = 0; i < 10000; i++) begin
      logic e_rdy1;
      logic e_rdy0;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 39) == 0);
      in_ctrl   = CTRL_W'($urandom_range(1, 511));
      in_data   = $urandom;
      #1;
      e_rdy1 = (q1.size() < 2);
      e_rdy0 = (q0.size() == 0) || out_ready;
      chk("rnd_ready", in_ready, e_rdy1);
      chk("rnd_valid", out_valid, q1.size() != 0);
      chk("rnd_occ", occupancy, q1.size());
      if (q1.size() != 0) chk("rnd_payload", {out_ctrl, out_data}, q1[0]);
      else                chk("rnd_bubble_ctrl", out_ctrl, 0);
      chk("rnd_z_ready", z_in_ready, e_rdy0);
      chk("rnd_z_valid", z_out_valid, q0.size() != 0);
      chk("rnd_z_occ", z_occupancy, q0.size());
      if (q0.size() != 0) chk("rnd_z_payload", {z_out_ctrl, z_out_data}, q0[0]);
      else                chk("rnd_z_bubble_ctrl", z_out_ctrl, 0);
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (q1.size() != 0 && out_ready) void'(q1.pop_front());
        if (in_valid && e_rdy1) q1.push_back({in_ctrl, in_data});
        if (q0.size() != 0 && out_ready) void'(q0.pop_front());
        if (in_valid && e_rdy0) q0.push_back({in_ctrl, in_data});
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
